// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RAW hazard scoreboard.
// An entry records one in-flight register write as it moves down the pipeline.
package hazard_pkg;

  // The dst field is sized for the largest supported register file.
  // Narrower indices are zero-extended into it.
  localparam int HZ_DST_W = 8;
  localparam int SEL_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [HZ_DST_W-1:0] dst;
    logic                is_load;
  } hz_entry_t;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search for one source operand: picks the youngest in-flight producer,
// then decides whether its data can be forwarded yet or the consumer must stall.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int REG_W    = 3,
  parameter int SEL_W    = sel_width(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0] i_entries,
  input  logic                  i_used,
  input  logic [REG_W-1:0]      i_src,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_stall_req
);

  logic [SEL_W-1:0] w_sel;
  logic             w_stall_req;

  always_comb begin
    w_sel       = SEL_W'(SEL_RF);
    w_stall_req = 1'b0;
    // Walk oldest to youngest so the youngest match is the last one to assign.
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_used && i_entries[k-1].valid &&
          (i_entries[k-1].dst == HZ_DST_W'(i_src))) begin
        if (!i_entries[k-1].is_load || (k >= LOAD_LAT)) begin
          w_sel       = SEL_W'(k);
          w_stall_req = 1'b0;
        end else begin
          w_sel       = SEL_W'(SEL_RF);
          w_stall_req = 1'b1;
        end
      end
    end
  end

  assign o_sel       = w_sel;
  assign o_stall_req = w_stall_req;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit: tracks in-flight writes, selects forwarding sources per operand,
// raises load-use stalls, squashes on branch flush and counts stall cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS    = 8,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int REG_W    = $clog2(NREGS),
  parameter int SEL_W    = sel_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_issue_valid,
  input  logic             i_issue_we,
  input  logic [REG_W-1:0] i_issue_dst,
  input  logic             i_issue_is_load,
  input  logic             i_rx_used,
  input  logic             i_ry_used,
  input  logic [REG_W-1:0] i_rx,
  input  logic [REG_W-1:0] i_ry,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [SEL_W-1:0] o_fw_rx_sel,
  output logic [SEL_W-1:0] o_fw_ry_sel,
  output logic [15:0]      o_stall_cnt
);

  // r_stage[k-1] holds pipeline stage k (stage 1 = EX).
  hz_entry_t [DEPTH-1:0] r_stage;
  logic [15:0]           r_stall_cnt;

  logic [SEL_W-1:0] w_rx_sel;
  logic [SEL_W-1:0] w_ry_sel;
  logic             w_rx_req;
  logic             w_ry_req;
  logic             w_stall;
  hz_entry_t        w_new;

  hazard_match #(
    .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_W(REG_W), .SEL_W(SEL_W)
  ) u_match_rx (
    .i_entries  (r_stage),
    .i_used     (i_rx_used),
    .i_src      (i_rx),
    .o_sel      (w_rx_sel),
    .o_stall_req(w_rx_req)
  );

  hazard_match #(
    .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .REG_W(REG_W), .SEL_W(SEL_W)
  ) u_match_ry (
    .i_entries  (r_stage),
    .i_used     (i_ry_used),
    .i_src      (i_ry),
    .o_sel      (w_ry_sel),
    .o_stall_req(w_ry_req)
  );

  // A flushed issue slot can never stall: the instruction is discarded anyway.
  assign w_stall = i_issue_valid & ~i_flush & (w_rx_req | w_ry_req);

  always_comb begin
    w_new         = '0;
    w_new.valid   = i_issue_valid & i_issue_we & ~w_stall & ~i_flush;
    w_new.dst     = HZ_DST_W'(i_issue_dst);
    w_new.is_load = i_issue_is_load;
  end

  // Stage boundary: issue -> stage 1 -> ... -> stage DEPTH -> regfile.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) begin
        if ((k == 1) && i_flush) begin
          r_stage[k] <= '0;
        end else begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall     = w_stall;
  assign o_fw_rx_sel = w_rx_sel;
  assign o_fw_ry_sel = w_ry_sel;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, randomized traffic against
// an age-based queue model, async reset mid-stall and stall-counter saturation.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREGS    = 8;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int REG_W    = 3;
  localparam int SEL_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             iv = 1'b0, iwe = 1'b0, ild = 1'b0, rxu = 1'b0, ryu = 1'b0, fl = 1'b0;
  logic [REG_W-1:0] idst = '0, irx = '0, iry = '0;
  logic             o_stall;
  logic [SEL_W-1:0] o_rx_sel, o_ry_sel;
  logic [15:0]      o_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREGS(NREGS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_issue_valid  (iv),
    .i_issue_we     (iwe),
    .i_issue_dst    (idst),
    .i_issue_is_load(ild),
    .i_rx_used      (rxu),
    .i_ry_used      (ryu),
    .i_rx           (irx),
    .i_ry           (iry),
    .i_flush        (fl),
    .o_stall        (o_stall),
    .o_fw_rx_sel    (o_rx_sel),
    .o_fw_ry_sel    (o_ry_sel),
    .o_stall_cnt    (o_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input bit ld, input int dst,
                       input bit ru, input int rx, input bit yu, input int ry, input bit f);
    iv = v; iwe = we; ild = ld; idst = REG_W'(dst);
    rxu = ru; irx = REG_W'(rx); ryu = yu; iry = REG_W'(ry); fl = f;
  endtask

  typedef struct {
    bit v, we, ld; int dst;
    bit ru; int rx; bit yu; int ry; bit f;
    bit e_stall; int e_rx, e_ry, e_cnt;
  } vec_t;

  function automatic vec_t mk(bit v, bit we, bit ld, int dst, bit ru, int rx, bit yu, int ry,
                              bit f, bit es, int erx, int ery, int ec);
    vec_t r;
    r.v = v; r.we = we; r.ld = ld; r.dst = dst; r.ru = ru; r.rx = rx; r.yu = yu; r.ry = ry;
    r.f = f; r.e_stall = es; r.e_rx = erx; r.e_ry = ery; r.e_cnt = ec;
    return r;
  endfunction

  // Reference model: list of issued writes, each tagged with its age in cycles.
  typedef struct { int dst; bit ld; int age; } wr_t;
  wr_t q[$];
  int  cnt_m;

  function automatic void lookup(input bit used, input int src, output int sel, output bit req);
    int best;
    best = DEPTH + 1;
    sel  = 0;
    req  = 1'b0;
    if (used) begin
      foreach (q[i]) if (q[i].dst == src && q[i].age < best) best = q[i].age;
      if (best <= DEPTH) begin
        bit ld_best;
        ld_best = 1'b0;
        foreach (q[i]) if (q[i].dst == src && q[i].age == best) ld_best = q[i].ld;
        if (!ld_best || best >= LOAD_LAT) sel = best;
        else req = 1'b1;
      end
    end
  endfunction

  vec_t tbl[$];

  initial begin
    int  e_rx, e_ry;
    bit  q_rx, q_ry, e_st;
    bit  rv, rwe, rld, rru, ryu_r, rf;
    int  rdst, rrx, rry;

    tbl.push_back(mk(1,1,0,3, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,1, 1,3,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,1,3,0, 0,0,2,0));
    tbl.push_back(mk(1,0,0,0, 1,3,0,0,0, 0,3,0,0));
    tbl.push_back(mk(1,0,0,0, 1,3,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,1,5, 0,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,6, 0,0,1,5,0, 1,0,0,0));
    tbl.push_back(mk(1,1,0,6, 0,0,1,5,0, 0,0,2,1));
    tbl.push_back(mk(0,0,0,0, 1,6,0,0,0, 0,1,0,1));
    tbl.push_back(mk(1,1,0,2, 0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,1,0,2, 1,2,0,0,0, 0,1,0,1));
    tbl.push_back(mk(1,0,0,0, 1,2,1,2,0, 0,1,1,1));
    tbl.push_back(mk(1,1,0,7, 0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,7,0,0,0, 0,1,0,1));
    tbl.push_back(mk(1,1,1,4, 0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,1,0,1, 0,0,0,0,1, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,4,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,1,1,5, 0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,1,0,6, 0,0,1,5,1, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0,1,5,0, 0,0,0,1));
    tbl.push_back(mk(1,1,1,3, 0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,3,1,3,0, 1,0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,3,1,3,0, 0,2,2,2));
    tbl.push_back(mk(1,1,1,6, 0,0,0,0,0, 0,0,0,2));
    tbl.push_back(mk(0,0,0,0, 1,6,0,0,0, 0,0,0,2));

    // Reset state.
    #3;
    chk("reset_stall", 32'(o_stall), 0);
    chk("reset_rx_sel", 32'(o_rx_sel), 0);
    chk("reset_ry_sel", 32'(o_ry_sel), 0);
    chk("reset_cnt", 32'(o_cnt), 0);
    #9 rst_n = 1'b1;

    // Directed vector table, one issue slot per entry.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 drive(tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].dst, tbl[i].ru, tbl[i].rx,
               tbl[i].yu, tbl[i].ry, tbl[i].f);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(o_stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_rx_sel", i), 32'(o_rx_sel), 32'(tbl[i].e_rx));
      chk($sformatf("vec%0d_ry_sel", i), 32'(o_ry_sel), 32'(tbl[i].e_ry));
      chk($sformatf("vec%0d_cnt", i), 32'(o_cnt), 32'(tbl[i].e_cnt));
    end

    // Randomized traffic against the queue model, starting from a fresh reset.
    @(posedge clk);
    #2 drive(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    q.delete();
    cnt_m = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      rv    = ($urandom_range(0, 5) != 0);
      rwe   = ($urandom_range(0, 3) != 0);
      rld   = ($urandom_range(0, 2) == 0);
      rdst  = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
      rru   = $urandom_range(0, 1);
      rrx   = $urandom_range(0, 4);
      ryu_r = $urandom_range(0, 1);
      rry   = $urandom_range(0, 4);
      rf    = ($urandom_range(0, 9) == 0);
      drive(rv, rwe, rld, rdst, rru, rrx, ryu_r, rry, rf);
      lookup(rru, rrx, e_rx, q_rx);
      lookup(ryu_r, rry, e_ry, q_ry);
      e_st = rv && !rf && (q_rx || q_ry);
      #1;
      chk("rand_stall", 32'(o_stall), 32'(e_st));
      chk("rand_rx_sel", 32'(o_rx_sel), 32'(e_rx));
      chk("rand_ry_sel", 32'(o_ry_sel), 32'(e_ry));
      chk("rand_cnt", 32'(o_cnt), 32'(cnt_m));
      if (rf) begin
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].age == 1) q.delete(i);
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        q[i].age++;
        if (q[i].age > DEPTH) q.delete(i);
      end
      if (rv && rwe && !e_st && !rf) q.push_back('{dst: rdst, ld: rld, age: 1});
      if (e_st && cnt_m < 65535) cnt_m++;
    end

    // Asynchronous reset in the middle of a load-use stall.
    @(posedge clk);
    #1 drive(1,1,1,5, 0,0,0,0,0);
    @(posedge clk);
    #1 drive(1,0,0,0, 1,5,1,5,0);
    #1 chk("pre_reset_stall", 32'(o_stall), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_stall", 32'(o_stall), 0);
    chk("async_reset_rx_sel", 32'(o_rx_sel), 0);
    chk("async_reset_cnt", 32'(o_cnt), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_no_hazard", 32'(o_stall), 0);

    // Counter saturation under a persistent load-use hazard held by forcing stage 1.
    #1 drive(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 force dut.r_stage = {20'd0, 1'b1, 8'd5, 1'b1};
    drive(1,0,0,0, 1,5,0,0,0);
    #1 chk("sat_stall_held", 32'(o_stall), 1);
    repeat (1000) @(posedge clk);
    #1 chk("sat_cnt_1000", 32'(o_cnt), 1000);
    repeat (64534) @(posedge clk);
    #1 chk("sat_cnt_fffe", 32'(o_cnt), 32'h0000FFFE);
    repeat (4466) @(posedge clk);
    #1 chk("sat_cnt_ffff", 32'(o_cnt), 32'h0000FFFF);
    chk("sat_stall_still", 32'(o_stall), 1);
    release dut.r_stage;
    drive(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b0;
    #1 chk("sat_reset_cnt", 32'(o_cnt), 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW hazard unit for the pipelined CPU, sitting between decode/issue and the execute-side forwarding muxes. It tracks every in-flight register write in a DEPTH-entry shift register, selects the youngest forwarding source for each operand, and raises a load-use stall when the matching producer's data is not yet available. It also squashes on branch flush and counts stall cycles for performance monitoring.

## Interface
Parameters:
- NREGS, 8, architectural register count; REG_W = $clog2(NREGS)
- DEPTH, 3, tracked stages after issue (stage 1 = EX ... stage DEPTH = last stage before regfile write)
- LOAD_LAT, 2, first stage index at which load data is forwardable; legal range 1..DEPTH
- SEL_W, $clog2(DEPTH+1), forwarding-select width

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_issue_valid  in  1  instruction presented at issue this cycle
- i_issue_we  in  1  issuing instruction writes a register (includes implicit R7 link writes)
- i_issue_dst  in  REG_W  destination register
- i_issue_is_load  in  1  issuing instruction is a load
- i_rx_used, i_ry_used  in  1  issuing instruction reads Rx / Ry
- i_rx, i_ry  in  REG_W  source register indices
- i_flush  in  1  branch taken: squash stage-1 entry and issuing instruction
- o_stall  out  1  hold issue/decode this cycle
- o_fw_rx_sel, o_fw_ry_sel  out  SEL_W  0 = register file, k = forward from stage k
- o_stall_cnt  out  16  saturating stall-cycle counter

## Operation
- Entry per stage: valid, dst, is_load. Stage k is a register; stage 1 is fed from issue.
- Match per source (only when *_used): scan stages 1..DEPTH; the lowest index with valid & dst == src wins (youngest producer).
- Winner at stage k ready if !is_load, or is_load && k >= LOAD_LAT. Ready → sel = k. Not ready → sel = 0 and stall request.
- No match, or source unused → sel = 0, no stall request.
- o_stall = i_issue_valid & !i_flush & (stall_req_rx | stall_req_ry).
- Advance every cycle: stage k+1 <= stage k; stage DEPTH drops out (regfile write-through covers it).
- Stage 1 <= {valid = i_issue_valid & i_issue_we & !o_stall & !i_flush, dst, is_load}; a stall inserts a bubble.
- i_flush: stage-1 entry is invalidated in the same shift (stage 2 <= bubble), and the issuing instruction is not entered. Flush overrides stall.
- o_stall_cnt increments on every cycle with o_stall = 1 and saturates at 16'hFFFF.
- No hardwired-zero register: all NREGS indices are tracked.

## Timing
- Reset (async assert, sync-release assumed upstream): all valid = 0, o_stall_cnt = 0; consequently o_stall = 0 and both sels = 0.
- o_stall and sels are combinational from current entries plus issue inputs; state updates on the rising edge of i_clk.
- Load-use with LOAD_LAT = L: a consumer issued directly after a load stalls L-1 cycles, then forwards from stage L.
- ALU producer: a back-to-back consumer never stalls; it forwards from stage 1.
- A producer that has left stage DEPTH gives sel = 0 (regfile).
- Rx and Ry matching the same producer: both sels are equal, and a single stall condition applies.
- A reset mid-stall clears all entries; the next cycle sees no hazard.

## Structure
- hazard_pkg: the entry struct typedef (valid, dst, is_load), function sel_width(depth), and SEL_RF = 0 constant.
- Sub-module hazard_match: priority search over the entry vector for one source, returning {sel, stall_req}. It is instantiated twice (Rx, Ry).
- Top level: entry shift register, stall/flush gating, and the stall counter.

## Test plan
- Reset with i_reset_n = 0 mid-traffic → o_stall = 0, sels = 0, and o_stall_cnt = 0 immediately (async).
- ALU writes R3, next instruction reads Rx = R3 → o_fw_rx_sel = 1, o_stall = 0; one cycle later, a reader of R3 gets sel = 2.
- LOAD_LAT = 2: load to R5, then a consumer with Ry = R5 → o_stall = 1 for 1 cycle, then o_fw_ry_sel = 2 and o_stall_cnt = 1.
- Two writers to R2 in flight (stages 1 and 2) → sel = 1 (youngest). Writer of R7 (link) followed by a reader of R7 → sel = 1.
- Load to R4 with i_flush asserted on the next issue, then a reader of R4 issues after it → that later reader is not stalled by the squashed entry; if the load itself is in stage 1 at flush, it is removed.
- Hold a persistent load-use hazard for 70000 stall cycles by forcing entries → o_stall_cnt saturates at 16'hFFFF.
